// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM access arbiter slice.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side command/response bus shared by all NUM_REQ requesters.
interface ram_access_arbiter_if #(
  parameter int unsigned NUM_REQ    = ram_arb_pkg::DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = ram_arb_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ram_arb_pkg::DEF_DATA_WIDTH
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_accept;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  // Requesters drive commands and observe accept/response.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_accept, rsp_valid, rsp_rdata
  );

  // The arbiter observes commands and drives accept/response.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_accept, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_access_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping upward.
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_REQ,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  logic w_found;

  // Two passes: indices at/above ptr first, then the wrapped-around lower part.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    w_found    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && req[k] && (IW'(k) >= ptr)) begin
        w_found       = 1'b1;
        gnt_onehot[k] = 1'b1;
        gnt_idx       = IW'(k);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && req[k]) begin
        w_found       = 1'b1;
        gnt_onehot[k] = 1'b1;
        gnt_idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-outstanding ram_controller among
// NUM_REQ requesters. One command in flight; all outputs registered.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_access_arbiter_if.slave   req_bus,
  output logic                  ram_read_en,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ready,
  output logic                  busy
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  arb_state_t            r_state;
  logic [IW-1:0]         r_ptr;
  logic [NUM_REQ-1:0]    r_gsel;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [NUM_REQ-1:0]    r_accept;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic                  r_read_en;
  logic                  r_write_en;
  logic                  r_busy;

  logic [NUM_REQ-1:0]    w_gnt_onehot;
  logic [IW-1:0]         w_gnt_idx;
  logic [IW-1:0]         w_ptr_next;
  logic                  w_start;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req        (req_bus.req_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx)
  );

  // Grant condition and the pointer value following the granted requester.
  always_comb begin
    w_start    = (r_state == IDLE) && ram_ready && (|req_bus.req_valid);
    w_ptr_next = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IW'(1));
  end

  // Route the granted requester's command fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_onehot[k]) begin
        w_sel_we    = req_bus.req_we[k];
        w_sel_addr  = req_bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_bus.req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Command FSM: latch at grant, pulse the enable, wait for read data, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gsel      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_accept    <= '0;
      r_rsp_valid <= '0;
      r_read_en   <= 1'b0;
      r_write_en  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_accept    <= '0;
      r_rsp_valid <= '0;
      r_read_en   <= 1'b0;
      r_write_en  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= ISSUE;
            r_gsel     <= w_gnt_onehot;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_ptr      <= w_ptr_next;
            r_accept   <= w_gnt_onehot;
            r_read_en  <= ~w_sel_we;
            r_write_en <= w_sel_we;
            r_busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_state     <= RESP;
            r_rsp_valid <= r_gsel;
          end else begin
            r_state <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_state     <= RESP;
          r_rdata     <= ram_rdata;
          r_rsp_valid <= r_gsel;
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_bus.req_accept = r_accept;
  assign req_bus.rsp_valid  = r_rsp_valid;
  assign req_bus.rsp_rdata  = r_rdata;
  assign ram_read_en        = r_read_en;
  assign ram_write_en       = r_write_en;
  assign ram_addr           = r_addr;
  assign ram_wdata          = r_wdata;
  assign busy               = r_busy;

endmodule
